aurora_rx_frame_check: RTL
==========================

// Module: aurora_rx_frame_check
// PURPOSE
//   Receive-side consumer for the augmented-Aurora AXI-Stream master port, in the user_clk_out domain.
//   Assembles fixed-length frames, e.g. the periodic two-word {0x5, 0x3} stimulus, into a parallel register.
//   Flags short, long and stalled frames, and keeps saturating good-frame and error counters for debug/ILA.
// PARAMETERS
//   DATA_W     32   width of the stream word
//   FRAME_LEN  2    expected words per frame (>=1); the word carrying tlast is word FRAME_LEN-1
//   CNT_W      16   width of frame_count and err_count (saturating)
//   TIMEOUT    255  max idle cycles between words inside a frame before abort (>=1)
// PORTS
//   user_clk       in   1                 stream clock (Aurora user_clk_out)
//   reset_n        in   1                 asynchronous, active-low reset
//   clear          in   1                 sync pulse: zero both counters and sticky error flags
//   s_axis_tvalid  in   1                 slave word valid
//   s_axis_tdata   in   DATA_W            slave word data
//   s_axis_tlast   in   1                 last word of frame
//   s_axis_tready  out  1                 slave ready
//   frame_data     out  FRAME_LEN*DATA_W  last good frame; word 0 in LSBs
//   frame_valid    out  1                 1-cycle pulse: frame_data just updated
//   frame_count    out  CNT_W             good frames received (saturates at all-ones)
//   err_count      out  CNT_W             erroneous frames (saturates at all-ones)
//   err_short      out  1                 sticky: tlast before FRAME_LEN words
//   err_long       out  1                 sticky: FRAME_LEN words without tlast
//   err_timeout    out  1                 sticky: mid-frame gap exceeded TIMEOUT
// BEHAVIOUR
//   Reset (async assert, sync release)
//     All outputs 0: s_axis_tready=0, frame_data=0, counters=0, flags=0. FSM=IDLE.
//     s_axis_tready is registered and rises 1 cycle after reset release; it then stays 1 (no backpressure).
//   Beat: a cycle with s_axis_tvalid && s_axis_tready. Word index widx counts 0..FRAME_LEN-1.
//   Each beat writes its word into shadow slot widx; frame_data is never partially updated.
//   FSM states
//     IDLE: on a beat, store word 0 and go to RECV (widx=1).
//       Exception: FRAME_LEN==1 with tlast is a complete frame; the beat stays in IDLE.
//     RECV: on a beat, store word widx.
//       tlast && widx==FRAME_LEN-1: good frame, go to IDLE.
//       tlast && widx<FRAME_LEN-1: short error, go to IDLE.
//       !tlast && widx==FRAME_LEN-1: long error, go to DROP.
//       Otherwise widx++.
//       Gap counter resets on every beat and increments on idle cycles.
//       Gap counter reaching TIMEOUT: timeout error, go to IDLE, partial frame discarded.
//     DROP: consume beats; the beat with tlast returns to IDLE. No timeout in DROP.
//   Good frame
//     Cycle after the last beat: frame_data <= shadow incl. last word, frame_valid=1 for 1 cycle.
//     Same edge: frame_count++ (saturating).
//     Latency from last beat to frame_valid is 1 cycle.
//   Error
//     Sticky flag set and err_count++ (saturating) in the cycle after detection.
//     A long frame counts once, at entry to DROP. frame_data is unchanged and no frame_valid.
//   Back-to-back frames: a beat in the cycle right after tlast starts a new frame, no bubble.
//   clear
//     Zeroes counters and flags. Same-cycle increment/set loses to clear.
//     FSM, shadow and frame_data are not affected.
//   reset_n mid-frame: immediate return to reset state; the partial frame is lost.
// TESTING
//   1 Reset release, then {0x5,0x3 tlast} -> frame_data=0x00000003_00000005, frame_valid 1 cycle after last beat, frame_count=1.
//   2 Single beat 0x7 with tlast (FRAME_LEN=2) -> err_short=1, err_count=1, frame_data unchanged, no frame_valid.
//   3 Three beats, tlast on 3rd -> err_long=1, err_count=1; next {0x5,0x3} frame is accepted, frame_count++.
//   4 Beat 0x5, then 256 idle cycles (TIMEOUT=255) -> err_timeout=1; a following 0x3 tlast is a short error, err_count=2.
//   5 Continuous {0x5,0x3} x1000, tvalid always high -> frame_count=1000, 1000 frame_valid pulses, no errors.
//   6 CNT_W=4: 20 good frames -> frame_count=15; clear coincident with a good frame -> frame_count=0; reset_n low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/aurora_rx_frame_check.sv
// Receive-side frame checker for the Aurora AXI-Stream master port.
// Assembles FRAME_LEN-word frames into a parallel register and flags
// short, long and stalled frames with saturating debug counters.
module aurora_rx_frame_check #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 2,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                        user_clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        s_axis_tvalid,
  input  logic [DATA_W-1:0]           s_axis_tdata,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [FRAME_LEN*DATA_W-1:0] frame_data,
  output logic                        frame_valid,
  output logic [CNT_W-1:0]            frame_count,
  output logic [CNT_W-1:0]            err_count,
  output logic                        err_short,
  output logic                        err_long,
  output logic                        err_timeout
);

  localparam int WIDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GAP_W  = $clog2(TIMEOUT + 1);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e                           state_q;
  logic                             tready_q;
  logic [WIDX_W-1:0]                widx_q;
  logic [GAP_W-1:0]                 gap_q;
  logic [FRAME_LEN-1:0][DATA_W-1:0] shadow_q;
  logic [FRAME_LEN-1:0][DATA_W-1:0] shadow_d;

  logic [FRAME_LEN*DATA_W-1:0]      frame_data_q;
  logic                             frame_valid_q;
  logic [CNT_W-1:0]                 frame_count_q;
  logic [CNT_W-1:0]                 err_count_q;
  logic                             err_short_q;
  logic                             err_long_q;
  logic                             err_timeout_q;

  logic                             beat;
  logic [WIDX_W-1:0]                slot;
  logic                             good_frame;
  logic                             short_err;
  logic                             long_err;
  logic                             timeout_err;

  // Beat decode: which slot this word lands in and how the frame ends.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    beat        = s_axis_tvalid && tready_q;
    slot        = (state_q == RECV) ? widx_q : '0;
    shadow_d    = shadow_q;
    good_frame  = 1'b0;
    short_err   = 1'b0;
    long_err    = 1'b0;
    timeout_err = 1'b0;
    if (beat && (state_q != DROP)) begin
      shadow_d[slot] = s_axis_tdata;
      good_frame     = s_axis_tlast  && (slot == LAST_IDX);
      short_err      = s_axis_tlast  && (slot != LAST_IDX);
      long_err       = !s_axis_tlast && (slot == LAST_IDX);
    end
    // The gap counter holds the number of idle cycles already seen, so an
    // idle cycle arriving with it at TIMEOUT is one idle cycle too many.
    if (!beat && (state_q == RECV) && (gap_q == GAP_MAX)) begin
      timeout_err = 1'b1;
    end
  end

  // Frame FSM: word index, inter-word gap timer and the shadow frame.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tready_q <= 1'b0;
      widx_q   <= '0;
      gap_q    <= '0;
      // NOTE: the shadow is only a few flops, so it is reset along with the
      // rest; a frame can never expose stale contents after reset.
      shadow_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples the pre-edge values of its neighbours.
      tready_q <= 1'b1;
      shadow_q <= shadow_d;
      if (beat || timeout_err) begin
        gap_q <= '0;
      end else if (state_q == RECV) begin
        gap_q <= gap_q + 1'b1;
      end
      unique case (state_q)
        IDLE, RECV: begin
          if (beat) begin
            if (s_axis_tlast) begin
              state_q <= IDLE;
              widx_q  <= '0;
            end else if (long_err) begin
              state_q <= DROP;
              widx_q  <= '0;
            end else begin
              state_q <= RECV;
              widx_q  <= slot + 1'b1;
            end
          end else if (timeout_err) begin
            state_q <= IDLE;
            widx_q  <= '0;
          end
        end
        DROP: begin
          if (beat && s_axis_tlast) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          widx_q  <= '0;
        end
      endcase
    end
  end

  // Frame publication, saturating counters and sticky flags; clear wins.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      frame_valid_q <= good_frame;
      if (good_frame) begin
        frame_data_q <= shadow_d;
      end
      if (clear) begin
        frame_count_q <= '0;
        err_count_q   <= '0;
        err_short_q   <= 1'b0;
        err_long_q    <= 1'b0;
        err_timeout_q <= 1'b0;
      end else begin
        if (good_frame && (frame_count_q != '1)) begin
          frame_count_q <= frame_count_q + 1'b1;
        end
        if ((short_err || long_err || timeout_err) && (err_count_q != '1)) begin
          err_count_q <= err_count_q + 1'b1;
        end
        if (short_err)   err_short_q   <= 1'b1;
        if (long_err)    err_long_q    <= 1'b1;
        if (timeout_err) err_timeout_q <= 1'b1;
      end
    end
  end

  assign s_axis_tready = tready_q;
  assign frame_data    = frame_data_q;
  assign frame_valid   = frame_valid_q;
  assign frame_count   = frame_count_q;
  assign err_count     = err_count_q;
  assign err_short     = err_short_q;
  assign err_long      = err_long_q;
  assign err_timeout   = err_timeout_q;

endmodule
